// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: sole driver of the vga_adapter pixel port, shared by three requesters and a full-screen clear sweep.
// Define VGA_PLOT_ARBITER_ROUND_ROBIN_EN for round-robin arbitration; without it, requester 0 > 1 > 2 by fixed priority.
module vga_plot_arbiter #(
  parameter int X_MAX          = 160,
  parameter int Y_MAX          = 120,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clear_req,
  input  logic [2:0]  clear_colour,
  input  logic [2:0]  req_valid,
  input  logic [23:0] req_x,
  input  logic [23:0] req_y,
  input  logic [8:0]  req_colour,
  output logic [2:0]  req_ready,
  output logic [7:0]  out_x,
  output logic [7:0]  out_y,
  output logic [2:0]  out_colour,
  output logic        plot,
  output logic        busy_clear,
  output logic [1:0]  grant_id
);
  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_SERVE = 2'd2;
  localparam logic [7:0] X_LAST  = 8'(X_MAX - 1);
  localparam logic [7:0] Y_LAST  = 8'(Y_MAX - 1);
  localparam logic [8:0] X_LIM   = 9'(X_MAX);
  localparam logic [8:0] Y_LIM   = 9'(Y_MAX);

  logic [1:0] state_q, state_d;
  logic [7:0] cx_q, cx_d, cy_q, cy_d;
  logic [7:0] x_q, x_d, y_q, y_d;
  logic [2:0] col_q, col_d;
  logic       plot_q, plot_d;
  logic [1:0] gid_q, gid_d;
  logic [1:0] win;
  logic [7:0] sel_x, sel_y;
  logic [2:0] sel_c;
  logic       serve, xfer, in_range, last_x, last_y;

`ifdef VGA_PLOT_ARBITER_ROUND_ROBIN_EN
  logic [1:0] last_q, c0, c1, c2;

  function automatic logic [1:0] nxt(input logic [1:0] a);
    return (a == 2'd2) ? 2'd0 : a + 2'd1;
  endfunction

  // Round-robin: search starts at the requester after the last winner
  always_comb begin
    c0  = nxt(last_q);
    c1  = nxt(c0);
    c2  = nxt(c1);
    win = req_valid[c0] ? c0 : req_valid[c1] ? c1 : c2;
  end

  // Pointer moves only when a transfer actually happens
  always_ff @(posedge clock) begin
    if (!reset_n) last_q <= 2'd2;
    else if (xfer) last_q <= win;
  end
`else
  assign win = req_valid[0] ? 2'd0 : req_valid[1] ? 2'd1 : 2'd2;
`endif

  // Clear always beats a simultaneous request; nothing is granted outside S_SERVE or in reset
  assign serve      = reset_n && state_q == S_SERVE && !clear_req;
  assign xfer       = serve && |req_valid;
  assign req_ready  = xfer ? 3'b001 << win : 3'b000;
  assign busy_clear = reset_n && state_q == S_CLEAR;
  assign sel_x      = win == 2'd0 ? req_x[7:0] : win == 2'd1 ? req_x[15:8] : req_x[23:16];
  assign sel_y      = win == 2'd0 ? req_y[7:0] : win == 2'd1 ? req_y[15:8] : req_y[23:16];
  assign sel_c      = win == 2'd0 ? req_colour[2:0] : win == 2'd1 ? req_colour[5:3] : req_colour[8:6];
  assign in_range   = {1'b0, sel_x} < X_LIM && {1'b0, sel_y} < Y_LIM;
  assign last_x     = cx_q == X_LAST;
  assign last_y     = cy_q == Y_LAST;
  assign out_x      = x_q;
  assign out_y      = y_q;
  assign out_colour = col_q;
  assign plot       = plot_q;
  assign grant_id   = gid_q;

  // Next-state: clear sweep in raster order, or one accepted pixel per cycle
  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    x_d     = x_q;
    y_d     = y_q;
    col_d   = col_q;
    plot_d  = 1'b0;
    gid_d   = gid_q;
    case (state_q)
      S_INIT: state_d = (CLEAR_ON_RESET || clear_req) ? S_CLEAR : S_SERVE;
      S_CLEAR: begin
        x_d     = cx_q;
        y_d     = cy_q;
        col_d   = clear_colour;
        plot_d  = 1'b1;
        cx_d    = last_x ? 8'd0 : cx_q + 8'd1;
        cy_d    = last_x ? (last_y ? 8'd0 : cy_q + 8'd1) : cy_q;
        state_d = (last_x && last_y) ? S_SERVE : S_CLEAR;
      end
      S_SERVE: begin
        state_d = clear_req ? S_CLEAR : S_SERVE;
        gid_d   = xfer ? win : gid_q;
        plot_d  = xfer && in_range;
        x_d     = plot_d ? sel_x : x_q;
        y_d     = plot_d ? sel_y : y_q;
        col_d   = plot_d ? sel_c : col_q;
      end
      default: state_d = S_INIT;
    endcase
  end

  // State and output registers; reset aborts any sweep in progress
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_INIT;
      cx_q    <= 8'd0;
      cy_q    <= 8'd0;
      x_q     <= 8'd0;
      y_q     <= 8'd0;
      col_q   <= 3'd0;
      plot_q  <= 1'b0;
      gid_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      x_q     <= x_d;
      y_q     <= y_d;
      col_q   <= col_d;
      plot_q  <= plot_d;
      gid_q   <= gid_d;
    end
  end
endmodule
